// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter for a single memory port.
// Round-robin on ties, alignment checking, and a bounded wait for mem_ready.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_funct3,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err,
  output logic              busy
);

  localparam int unsigned CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TIMEOUT_M = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM_IF = 2'd1,
    MEM_LS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic               last_ls, last_ls_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               mis, mis_nx;

  logic               if_gnt_nx, ls_gnt_nx, if_done_nx, ls_done_nx, err_nx, busy_nx;
  logic [DATA_W-1:0]  if_rdata_nx, ls_rdata_nx;
  logic               mem_req_nx, mem_we_nx;
  logic [2:0]         mem_funct3_nx;
  logic [ADDR_W-1:0]  mem_addr_nx;
  logic [DATA_W-1:0]  mem_wdata_nx;

  logic               pick_ls_c, if_mis_c, ls_mis_c;
  logic               fin_c, fin_err_c;
  logic [DATA_W-1:0]  fin_data_c;

  // Alignment: funct3[1:0] encodes size (byte / half / word)
  always_comb begin
    if_mis_c = (if_addr[1:0] != 2'b00);
    case (ls_funct3[1:0])
      2'b00:   ls_mis_c = 1'b0;
      2'b01:   ls_mis_c = ls_addr[0];
      default: ls_mis_c = (ls_addr[1:0] != 2'b00);
    endcase
  end

  // LS wins when alone, or on a tie when IF was served last
  assign pick_ls_c = ls_req && (!if_req || !last_ls);

  always_comb begin
    state_nx      = state;
    last_ls_nx    = last_ls;
    cnt_nx        = cnt;
    mis_nx        = mis;
    if_gnt_nx     = 1'b0;
    ls_gnt_nx     = 1'b0;
    if_done_nx    = 1'b0;
    ls_done_nx    = 1'b0;
    err_nx        = 1'b0;
    if_rdata_nx   = if_rdata;
    ls_rdata_nx   = ls_rdata;
    mem_req_nx    = 1'b0;
    mem_we_nx     = 1'b0;
    mem_funct3_nx = 3'b000;
    mem_addr_nx   = '0;
    mem_wdata_nx  = '0;
    fin_c         = 1'b0;
    fin_err_c     = 1'b0;
    fin_data_c    = '0;

    case (state)
      IDLE: begin
        if (if_req || ls_req) begin
          cnt_nx = '0;
          if (pick_ls_c) begin
            state_nx   = MEM_LS;
            ls_gnt_nx  = 1'b1;
            last_ls_nx = 1'b1;
            mis_nx     = ls_mis_c;
            if (!ls_mis_c) begin
              mem_req_nx    = 1'b1;
              mem_we_nx     = ls_we;
              mem_funct3_nx = ls_funct3;
              mem_addr_nx   = ls_addr;
              mem_wdata_nx  = ls_wdata;
            end
          end else begin
            state_nx   = MEM_IF;
            if_gnt_nx  = 1'b1;
            last_ls_nx = 1'b0;
            mis_nx     = if_mis_c;
            if (!if_mis_c) begin
              mem_req_nx    = 1'b1;
              mem_funct3_nx = 3'b010;
              mem_addr_nx   = if_addr;
            end
          end
        end
      end

      MEM_IF, MEM_LS: begin
        if (mis) begin
          fin_c     = 1'b1;
          fin_err_c = 1'b1;
        end else if (mem_ready) begin
          fin_c      = 1'b1;
          fin_data_c = mem_rdata;
        end else if (cnt == CNT_W'(TIMEOUT_M)) begin
          fin_c     = 1'b1;
          fin_err_c = 1'b1;
        end else begin
          cnt_nx        = cnt + CNT_W'(1);
          mem_req_nx    = mem_req;
          mem_we_nx     = mem_we;
          mem_funct3_nx = mem_funct3;
          mem_addr_nx   = mem_addr;
          mem_wdata_nx  = mem_wdata;
        end

        if (fin_c) begin
          state_nx = DONE;
          cnt_nx   = '0;
          err_nx   = fin_err_c;
          if (state == MEM_LS) begin
            ls_done_nx  = 1'b1;
            ls_rdata_nx = fin_data_c;
          end else begin
            if_done_nx  = 1'b1;
            if_rdata_nx = fin_data_c;
          end
        end
      end

      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_ls    <= 1'b0;
      cnt        <= '0;
      mis        <= 1'b0;
      if_gnt     <= 1'b0;
      ls_gnt     <= 1'b0;
      if_done    <= 1'b0;
      ls_done    <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_funct3 <= 3'b000;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nx;
      last_ls    <= last_ls_nx;
      cnt        <= cnt_nx;
      mis        <= mis_nx;
      if_gnt     <= if_gnt_nx;
      ls_gnt     <= ls_gnt_nx;
      if_done    <= if_done_nx;
      ls_done    <= ls_done_nx;
      err        <= err_nx;
      busy       <= busy_nx;
      if_rdata   <= if_rdata_nx;
      ls_rdata   <= ls_rdata_nx;
      mem_req    <= mem_req_nx;
      mem_we     <= mem_we_nx;
      mem_funct3 <= mem_funct3_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants/completions,
// a negedge monitor pops and compares whenever the DUT pulses gnt or done.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_done;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_gnt, ls_done;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        err, busy;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ls;
    logic [31:0] data;
    logic        err;
  } done_t;

  done_t exp_done[$];
  logic  exp_gnt[$];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int gnt_seen = 0, done_seen = 0, mem_cycles = 0;
  int gnt_cyc = 0, done_cyc = 0;
  int waits = 0;
  int wcnt = 0;
  logic        mem_chk = 1'b0;
  logic [67:0] exp_mem = '0;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: ready after `waits` stalled cycles of a held request
  always @(negedge clk) begin
    if (mem_req) begin
      mem_ready = (wcnt == waits);
      wcnt++;
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (if_gnt || ls_gnt) begin
        check("gnt_exclusive", 68'(if_gnt & ls_gnt), 68'(0));
        if (exp_gnt.size() == 0) check("gnt_unexpected", 68'(1), 68'(0));
        else check("gnt_who", 68'(ls_gnt), 68'(exp_gnt.pop_front()));
        gnt_seen++;
        gnt_cyc = cyc;
      end
      if (if_done || ls_done) begin
        if (exp_done.size() == 0) check("done_unexpected", 68'(1), 68'(0));
        else check("done_resp",
                   68'({ls_done, (ls_done ? ls_rdata : if_rdata), err}),
                   68'(exp_done.pop_front()));
        done_seen++;
        done_cyc = cyc;
      end else if (err) begin
        check("err_without_done", 68'(err), 68'(0));
      end
      if (mem_req) begin
        mem_cycles++;
        if (mem_chk) check("mem_fields", {mem_we, mem_funct3, mem_addr, mem_wdata}, exp_mem);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int base, input int n);
    int k = 0;
    while (gnt_seen < base + n && k < 60) begin step(); k++; end
    if (gnt_seen < base + n) check("gnt_timeout", 68'(gnt_seen), 68'(base + n));
  endtask

  task automatic wait_done(input int base);
    int k = 0;
    while (done_seen <= base && k < 60) begin step(); k++; end
    if (done_seen <= base) check("done_timeout", 68'(done_seen), 68'(base + 1));
  endtask

  task automatic ls_op(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int w,
                       input logic [31:0] rd, input done_t exp, input int exp_lat,
                       input int exp_memcyc);
    int g, d;
    waits = w; mem_rdata = rd;
    exp_mem = {we, f3, a, wd}; mem_chk = 1'b1;
    exp_gnt.push_back(1'b1);
    exp_done.push_back(exp);
    g = gnt_seen; d = done_seen; mem_cycles = 0;
    ls_we = we; ls_funct3 = f3; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
    wait_gnt(g, 1);
    ls_req = 1'b0; ls_addr = '0; ls_wdata = '0;
    wait_done(d);
    check({name, "_latency"}, 68'(done_cyc - gnt_cyc), 68'(exp_lat));
    check({name, "_memcycles"}, 68'(mem_cycles), 68'(exp_memcyc));
    step();
    mem_chk = 1'b0;
  endtask

  initial begin
    int g, d;
    rst = 1'b1; if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_funct3 = '0;
    ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
    step(); step();
    check("reset_outputs",
          68'({if_gnt, if_done, ls_gnt, ls_done, mem_req, mem_we, err, busy, mem_funct3}), 68'(0));
    check("reset_data", {4'h0, if_rdata, ls_rdata}, 68'(0));
    check("reset_mem_addr", {4'h0, mem_addr, mem_wdata}, 68'(0));

    // Tie right after reset: LS, IF, LS, IF
    rst = 1'b0;
    waits = 0; mem_rdata = 32'h11223344;
    if_addr = 32'h0000_0100; ls_addr = 32'h0000_0200; ls_funct3 = 3'b010;
    exp_gnt.push_back(1'b1); exp_gnt.push_back(1'b0);
    exp_gnt.push_back(1'b1); exp_gnt.push_back(1'b0);
    exp_done.push_back('{1'b1, 32'h11223344, 1'b0});
    exp_done.push_back('{1'b0, 32'h11223344, 1'b0});
    exp_done.push_back('{1'b1, 32'h11223344, 1'b0});
    exp_done.push_back('{1'b0, 32'h11223344, 1'b0});
    g = gnt_seen; d = done_seen;
    if_req = 1'b1; ls_req = 1'b1;
    wait_gnt(g, 4);
    if_req = 1'b0; ls_req = 1'b0;
    wait_done(d + 3);
    step();
    check("tie_grants", 68'(gnt_seen - g), 68'(4));

    // Lone fetch, zero-wait memory
    waits = 0; mem_rdata = 32'h0050_0093;
    exp_mem = {1'b0, 3'b010, 32'h10, 32'h0}; mem_chk = 1'b1;
    exp_gnt.push_back(1'b0);
    exp_done.push_back('{1'b0, 32'h0050_0093, 1'b0});
    g = gnt_seen; d = done_seen; mem_cycles = 0;
    if_addr = 32'h10; if_req = 1'b1;
    wait_gnt(g, 1);
    if_req = 1'b0;
    wait_done(d);
    check("fetch_latency", 68'(done_cyc - gnt_cyc), 68'(1));
    check("fetch_memcycles", 68'(mem_cycles), 68'(1));
    check("fetch_rdata", 68'(if_rdata), 68'(32'h0050_0093));
    step();
    mem_chk = 1'b0;

    // Store with three wait cycles
    ls_op("store", 1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 3, 32'hCAFE0001,
          '{1'b1, 32'hCAFE0001, 1'b0}, 4, 4);
    // Misaligned half
    ls_op("misalign", 1'b0, 3'b001, 32'h21, 32'h0, 0, 32'h12345678,
          '{1'b1, 32'h0, 1'b1}, 1, 0);
    check("if_rdata_hold", 68'(if_rdata), 68'(32'h0050_0093));
    // Byte access at odd address is aligned
    ls_op("byte_odd", 1'b0, 3'b100, 32'h23, 32'h0, 1, 32'h000000AB,
          '{1'b1, 32'h000000AB, 1'b0}, 2, 2);
    // Timeout
    ls_op("timeout", 1'b0, 3'b010, 32'h40, 32'h0, 1000, 32'h55555555,
          '{1'b1, 32'h0, 1'b1}, 15, 15);

    // Misaligned fetch
    waits = 0; mem_rdata = 32'h77777777;
    exp_gnt.push_back(1'b0);
    exp_done.push_back('{1'b0, 32'h0, 1'b1});
    g = gnt_seen; d = done_seen; mem_cycles = 0;
    if_addr = 32'h12; if_req = 1'b1;
    wait_gnt(g, 1);
    if_req = 1'b0;
    wait_done(d);
    check("fetch_mis_memcycles", 68'(mem_cycles), 68'(0));
    step();

    // Reset during MEM_LS: aborted, no done
    waits = 1000; mem_rdata = 32'h99999999;
    exp_gnt.push_back(1'b1);
    g = gnt_seen; d = done_seen;
    ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h44; ls_req = 1'b1;
    wait_gnt(g, 1);
    ls_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("abort_outputs",
          68'({if_gnt, if_done, ls_gnt, ls_done, mem_req, mem_we, err, busy, mem_funct3}), 68'(0));
    check("abort_data", {4'h0, if_rdata, ls_rdata}, 68'(0));
    check("abort_mem_addr", {4'h0, mem_addr, mem_wdata}, 68'(0));
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("abort_no_done", 68'(done_seen - d), 68'(0));
    check("abort_idle", 68'({busy, mem_req}), 68'(0));

    check("gnt_queue_empty", 68'(exp_gnt.size()), 68'(0));
    check("done_queue_empty", 68'(exp_done.size()), 68'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
